// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the CPU-to-memory arbiter slice.
package cpu_mem_pkg;

  localparam int unsigned CPU_ADDR_WIDTH = 16;
  localparam int unsigned CPU_DATA_WIDTH = 16;
  localparam int unsigned STREAK_WIDTH   = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
  typedef enum logic {OWNER_INST, OWNER_DATA} arb_owner_t;

endpackage

// File: rtl/cpu_mem_arb_pick.sv
// Data-priority arbitration with a streak limit that guarantees fetch progress.
module cpu_mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                    inst_req_valid,
  input  logic                    data_req_valid,
  input  logic [STREAK_WIDTH-1:0] streak,
  output logic                    grant_inst,
  output logic                    grant_data,
  output logic [STREAK_WIDTH-1:0] streak_next
);

  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);

  logic limit_hit;

  always_comb begin
    limit_hit   = (streak >= STREAK_MAX);
    grant_data  = data_req_valid & ~(inst_req_valid & limit_hit);
    grant_inst  = inst_req_valid & ~grant_data;
    streak_next = streak;
    if (grant_inst) begin
      streak_next = '0;
    end else if (grant_data) begin
      // Only a data win that made fetch wait counts toward the streak.
      if (inst_req_valid) begin
        streak_next = limit_hit ? STREAK_MAX : streak + 1'b1;
      end else begin
        streak_next = '0;
      end
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data requesters,
// one transaction outstanding at a time.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = CPU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = CPU_DATA_WIDTH,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_req_valid,
  input  logic                  inst_req_write,
  input  logic [ADDR_WIDTH-1:0] inst_req_addr,
  input  logic [DATA_WIDTH-1:0] inst_req_wdata,
  output logic                  inst_req_ready,
  output logic                  inst_resp_valid,
  output logic [DATA_WIDTH-1:0] inst_resp_rdata,
  input  logic                  data_req_valid,
  input  logic                  data_req_write,
  input  logic [ADDR_WIDTH-1:0] data_req_addr,
  input  logic [DATA_WIDTH-1:0] data_req_wdata,
  output logic                  data_req_ready,
  output logic                  data_resp_valid,
  output logic [DATA_WIDTH-1:0] data_resp_rdata,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_t              state_q, state_d;
  arb_owner_t              owner_q, owner_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d, streak_next;
  logic                    grant_inst, grant_data, load;

  cpu_mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .inst_req_valid(inst_req_valid),
    .data_req_valid(data_req_valid),
    .streak        (streak_q),
    .grant_inst    (grant_inst),
    .grant_data    (grant_data),
    .streak_next   (streak_next)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    streak_d        = streak_q;
    load            = 1'b0;
    inst_req_ready  = 1'b0;
    data_req_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Ready is combinational, so it must also be forced low while reset is held.
        if (reset && (grant_inst || grant_data)) begin
          load           = 1'b1;
          inst_req_ready = grant_inst;
          data_req_ready = grant_data;
          owner_d        = grant_data ? OWNER_DATA : OWNER_INST;
          streak_d       = streak_next;
          state_d        = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          inst_resp_valid = (owner_q == OWNER_INST);
          data_resp_valid = (owner_q == OWNER_DATA);
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    mem_valid       = (state_q == ARB_ISSUE);
    inst_resp_rdata = inst_resp_valid ? mem_rdata : '0;
    data_resp_rdata = data_resp_valid ? mem_rdata : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_INST;
      streak_q  <= '0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      if (load) begin
        mem_write <= grant_data ? data_req_write : inst_req_write;
        mem_addr  <= grant_data ? data_req_addr : inst_req_addr;
        mem_wdata <= grant_data ? data_req_wdata : inst_req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter.
module tb_cpu_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req_valid, inst_req_write, inst_req_ready, inst_resp_valid;
  logic [15:0] inst_req_addr, inst_req_wdata, inst_resp_rdata;
  logic        data_req_valid, data_req_write, data_req_ready, data_resp_valid;
  logic [15:0] data_req_addr, data_req_wdata, data_resp_rdata;
  logic        mem_valid, mem_write, mem_ready, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_mem_arbiter #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (16),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inst_req_valid (inst_req_valid),
    .inst_req_write (inst_req_write),
    .inst_req_addr  (inst_req_addr),
    .inst_req_wdata (inst_req_wdata),
    .inst_req_ready (inst_req_ready),
    .inst_resp_valid(inst_resp_valid),
    .inst_resp_rdata(inst_resp_rdata),
    .data_req_valid (data_req_valid),
    .data_req_write (data_req_write),
    .data_req_addr  (data_req_addr),
    .data_req_wdata (data_req_wdata),
    .data_req_ready (data_req_ready),
    .data_resp_valid(data_resp_valid),
    .data_resp_rdata(data_resp_rdata),
    .mem_valid      (mem_valid),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge (the drive point).
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req_valid = 1'b0; inst_req_write = 1'b0; inst_req_addr = '0; inst_req_wdata = '0;
    data_req_valid = 1'b0; data_req_write = 1'b0; data_req_addr = '0; data_req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_zero"},
             {16'd0, mem_valid, mem_write, inst_req_ready, data_req_ready,
              inst_resp_valid, data_resp_valid, 10'd0}, 32'd0);
    check_eq({tag, "_addr_wdata"}, {mem_addr, mem_wdata}, 32'd0);
    check_eq({tag, "_rdata"}, {inst_resp_rdata, data_resp_rdata}, 32'd0);
  endtask

  // Full 3-cycle transaction from the IDLE drive point; caller sets requests.
  task automatic run_txn(input string tag, input bit exp_inst, input logic [15:0] rd);
    #1;
    check_eq({tag, "_ready"}, {30'd0, inst_req_ready, data_req_ready},
             {30'd0, exp_inst, ~exp_inst});
    step();
    mem_ready = 1'b1;
    #1;
    check_eq({tag, "_issue"}, {31'd0, mem_valid}, 32'd1);
    step();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    #1;
    check_eq({tag, "_resp"}, {14'd0, inst_resp_valid, data_resp_valid, exp_inst ? inst_resp_rdata
             : data_resp_rdata}, {14'd0, exp_inst, ~exp_inst, rd});
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] order;
    clear_inputs();
    reset = 1'b0;
    #2;
    check_all_zero("reset");
    step();
    reset = 1'b1;

    // Single inst read, addr 0x0040, returns 0xBEEF.
    inst_req_valid = 1'b1; inst_req_addr = 16'h0040;
    #1;
    check_eq("t1_ready", {30'd0, inst_req_ready, data_req_ready}, 32'b10);
    check_eq("t1_idle_mem_valid", {31'd0, mem_valid}, 32'd0);
    step();
    inst_req_valid = 1'b0; mem_ready = 1'b1;
    #1;
    check_eq("t1_issue", {14'd0, mem_valid, mem_write, mem_addr}, {14'd0, 2'b10, 16'h0040});
    check_eq("t1_issue_ready", {31'd0, inst_req_ready}, 32'd0);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    check_eq("t1_resp", {13'd0, mem_valid, inst_resp_valid, data_resp_valid, inst_resp_rdata},
             {13'd0, 3'b010, 16'hBEEF});
    step();
    mem_rvalid = 1'b0;
    #1;
    check_eq("t1_after", {30'd0, inst_resp_valid, data_resp_valid}, 32'd0);

    // Data write with mem_ready stalled 3 cycles.
    data_req_valid = 1'b1; data_req_write = 1'b1;
    data_req_addr = 16'h1234; data_req_wdata = 16'h5A5A;
    #1;
    check_eq("t2_ready", {30'd0, inst_req_ready, data_req_ready}, 32'b01);
    step();
    data_req_valid = 1'b0; data_req_addr = 16'h0; data_req_wdata = 16'h0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check_eq($sformatf("t2_hold%0d_ctl", i), {30'd0, mem_valid, mem_write}, 32'b11);
      check_eq($sformatf("t2_hold%0d_fld", i), {mem_addr, mem_wdata}, 32'h1234_5A5A);
      step();
    end
    mem_ready = 1'b0;
    #1;
    check_eq("t2_wait_norv", {29'd0, mem_valid, inst_resp_valid, data_resp_valid}, 32'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 16'h0BAD;
    #1;
    check_eq("t2_resp", {30'd0, inst_resp_valid, data_resp_valid}, 32'b01);
    step();
    mem_rvalid = 1'b0; data_req_write = 1'b0;

    // Both requesting continuously: D,D,D,D,I,D,D,D,D,I (1 = inst).
    order = 10'b0000100001;
    inst_req_valid = 1'b1; data_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("t3_g%0d", i), order[9-i], 16'(16'h100 + i));
    end

    // Inst idle for 10 data grants; streak stays 0, so 4 contested data wins follow.
    inst_req_valid = 1'b0;
    for (int i = 0; i < 10; i++) run_txn($sformatf("t4_solo%0d", i), 1'b0, 16'(16'h200 + i));
    inst_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) run_txn($sformatf("t4_both%0d", i), 1'b0, 16'(16'h300 + i));
    run_txn("t4_inst", 1'b1, 16'h3F3F);

    // Reset asserted while in WAIT.
    inst_req_valid = 1'b0;
    data_req_valid = 1'b1; data_req_write = 1'b1;
    data_req_addr = 16'hC0DE; data_req_wdata = 16'hFACE;
    step();
    data_req_valid = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #1;
    check_eq("t5_pre_fields", {mem_addr, mem_wdata}, 32'hC0DE_FACE);
    reset = 1'b0; inst_req_valid = 1'b1; data_req_valid = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 16'h7777;
    #1;
    check_all_zero("t5_reset");
    step();
    reset = 1'b1; data_req_valid = 1'b0; data_req_write = 1'b0;
    inst_req_addr = 16'h0ACE;
    #1;
    check_eq("t5_grant", {28'd0, inst_req_ready, data_req_ready, inst_resp_valid,
             data_resp_valid}, 32'b1000);
    step();
    inst_req_valid = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    #1;
    check_eq("t5_issue", {15'd0, mem_valid, mem_addr}, {15'd0, 1'b1, 16'h0ACE});
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1357;
    #1;
    check_eq("t5_resp", {14'd0, inst_resp_valid, data_resp_valid, inst_resp_rdata},
             {14'd0, 2'b10, 16'h1357});
    step();
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
